tdm_demux14: RTL and testbench
==============================

// Module: tdm_demux14
// PURPOSE
//  Sequential 1-to-4 time-division demultiplexer; the receive-side counterpart of the 4:1 mux.
//  - Input: a serial stream of data beats. Each frame is four slots, A, B, C, D, in that order.
//  - Frame_sync marks the beat that carries slot A.
//  - The block locks to the frame and routes each beat into a holding register, one per channel.
//  - It flags sync errors and frame completion. Sits between a serial link deserializer and per-channel consumers.
// PARAMETERS
//  WIDTH     8   data width of one slot / one channel register
//  MISS_MAX  2   consecutive missing Frame_sync at slot A before lock is dropped (>=1)
// PORTS
//  Clk         in   1      rising-edge clock
//  Rst_n       in   1      asynchronous active-low reset
//  Din         in   WIDTH  slot data beat
//  Din_valid   in   1      Din carries a beat this cycle
//  Frame_sync  in   1      qualified by Din_valid; beat is slot A
//  A           out  WIDTH  channel A register
//  B           out  WIDTH  channel B register
//  C           out  WIDTH  channel C register
//  D           out  WIDTH  channel D register
//  Out_valid   out  4      one-hot 1-cycle pulse; bit0=A .. bit3=D updated this cycle
//  Sel         out  2      slot index expected for the next beat (00=A .. 11=D)
//  Locked      out  1      1 while in LOCKED state
//  Frame_done  out  1      1-cycle pulse, same cycle D updates
//  Sync_err    out  1      1-cycle pulse on misaligned Frame_sync
// BEHAVIOUR
//  Reset (Rst_n=0, async): all outputs 0, state HUNT, Sel=0, miss count 0. Mid-frame reset discards the partial frame.
//  Capture rule and latency:
//   - Only cycles with Din_valid=1 are beats. Frame_sync is ignored when Din_valid=0.
//   - All outputs are registered. A beat captured on edge N appears on A..D/Out_valid after edge N (1-cycle latency).
//   - Each channel register holds its value until its next capture.
//  State HUNT:
//   - Beats without Frame_sync are discarded; no Out_valid.
//   - A beat with Frame_sync: capture to A, Out_valid=0001, Sel<=1, miss<=0, go to LOCKED.
//  State LOCKED: every beat captures into the channel given by Sel, then Sel<=Sel+1 (wraps 3->0).
//   - Sel=0 with Frame_sync=1: normal case; miss<=0.
//   - Sel=0 with Frame_sync=0 (flywheel): capture to A anyway and increment miss.
//     - If miss reaches MISS_MAX, do NOT capture; go to HUNT with Sel<=0 and miss<=0.
//   - Sel!=0 with Frame_sync=1 (misalignment): Sync_err pulse.
//     - The beat is treated as slot A: capture to A, Sel<=1, miss<=0, stay LOCKED.
//     - The partial frame is abandoned: no Frame_done.
//   - Capture into D (Sel=3): Frame_done pulse in the same cycle as Out_valid[3].
//   - Din_valid=0: no state change, Out_valid=0, all pulses 0.
//  Back-to-back beats every cycle are supported; there is no backpressure.
//  Out_valid has at most one bit set. Sync_err and Frame_done are never high together.
// TESTING
//  1 Reset, then 2 clean frames with Din_valid=1 every cycle: 0x11,0x22,0x33,0x44 (sync on 0x11), repeated.
//    -> A..D = 11/22/33/44; Out_valid walks 1,2,4,8; Frame_done after 4th beat; Locked=1.
//  2 Beats 0x55,0x66 without sync while in HUNT.
//    -> A..D stay 0, Out_valid=0, Locked=0; first synced beat locks.
//  3 LOCKED, Sel=2, beat 0x77 with Frame_sync.
//    -> Sync_err=1, A=0x77, Sel=1, no Frame_done; C unchanged.
//  4 MISS_MAX=2; two frames without Frame_sync at slot A.
//    -> first frame: A captured, miss=1; second frame's slot-A beat: not captured, Locked=0, Sel=0.
//  5 Din_valid toggled 1/0 every cycle during a frame.
//    -> identical A..D as case 1; no pulses in idle cycles.
//  6 Assert Rst_n=0 mid-frame (Sel=2) for a partial cycle.
//    -> all outputs 0 immediately (async); after release, HUNT until next Frame_sync.

Source files
------------

// File: rtl/tdm_demux14_if.sv
// Serial-side and channel-side signal bundle for the 1:4 TDM demultiplexer.
// The master is the link side, which drives beats and watches the channels.
// The slave is the demux itself.
interface tdm_demux14_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] Din;
  logic             Din_valid;
  logic             Frame_sync;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [3:0]       Out_valid;
  logic [1:0]       Sel;
  logic             Locked;
  logic             Frame_done;
  logic             Sync_err;

  modport master (
    output Din, Din_valid, Frame_sync,
    input  A, B, C, D, Out_valid, Sel, Locked, Frame_done, Sync_err
  );

  modport slave (
    input  Din, Din_valid, Frame_sync,
    output A, B, C, D, Out_valid, Sel, Locked, Frame_done, Sync_err
  );
endinterface

// File: rtl/tdm_demux14.sv
// 1:4 time-division demultiplexer.
// It locks onto Frame_sync (slot A) and routes each valid beat into one of
// four channel registers. It flywheels through up to MISS_MAX-1 missing syncs
// before dropping lock. A sync seen in the wrong slot restarts the frame.
module tdm_demux14 #(
  parameter int WIDTH    = 8,
  parameter int MISS_MAX = 2
) (
  input logic          Clk,
  input logic          Rst_n,
  tdm_demux14_if.slave bus
);
  localparam int MW = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e                  state_q;
  logic [1:0]              sel_q;
  logic [MW-1:0]           miss_q;
  logic [3:0][WIDTH-1:0]   ch_q;
  logic [3:0]              ov_q;
  logic                    fd_q;
  logic                    se_q;

  // Frame tracking, channel capture and output pulse generation.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= HUNT;
      sel_q   <= '0;
      miss_q  <= '0;
      ch_q    <= '0;
      ov_q    <= '0;
      fd_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      ov_q <= '0;
      fd_q <= 1'b0;
      se_q <= 1'b0;
      if (bus.Din_valid) begin
        case (state_q)
          HUNT: begin
            // Beats are discarded until a sync-marked beat arrives.
            if (bus.Frame_sync) begin
              ch_q[0] <= bus.Din;
              ov_q    <= 4'b0001;
              sel_q   <= 2'd1;
              miss_q  <= '0;
              state_q <= LOCKED;
            end
          end
          LOCKED: begin
            if (sel_q != 2'd0 && bus.Frame_sync) begin
              // Misaligned sync: drop the partial frame and restart at slot A.
              se_q    <= 1'b1;
              ch_q[0] <= bus.Din;
              ov_q    <= 4'b0001;
              sel_q   <= 2'd1;
              miss_q  <= '0;
            end else if (sel_q == 2'd0 && !bus.Frame_sync &&
                         miss_q == MW'(MISS_MAX - 1)) begin
              // Too many missed syncs: this beat is not trusted and lock is dropped.
              state_q <= HUNT;
              sel_q   <= '0;
              miss_q  <= '0;
            end else begin
              ch_q[sel_q] <= bus.Din;
              ov_q        <= 4'b0001 << sel_q;
              sel_q       <= sel_q + 2'd1;
              if (sel_q == 2'd0)
                miss_q <= bus.Frame_sync ? '0 : miss_q + MW'(1);
              if (sel_q == 2'd3)
                fd_q <= 1'b1;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign bus.A          = ch_q[0];
  assign bus.B          = ch_q[1];
  assign bus.C          = ch_q[2];
  assign bus.D          = ch_q[3];
  assign bus.Out_valid  = ov_q;
  assign bus.Sel        = sel_q;
  assign bus.Locked     = (state_q == LOCKED);
  assign bus.Frame_done = fd_q;
  assign bus.Sync_err   = se_q;
endmodule

// File: tb/tb_tdm_demux14.sv
// Scoreboard bench for tdm_demux14.
// The driver pushes a hand-computed expected output for every beat that
// should produce one. The monitor pops and compares an entry whenever the DUT
// raises any output pulse.
module tb_tdm_demux14;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  tdm_demux14_if #(.WIDTH(8)) bus ();

  tdm_demux14 #(.WIDTH(8), .MISS_MAX(2)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] ov;
    logic [7:0] a, b, c, d;
    logic       fd, se;
    logic [1:0] sel;
    logic       lk;
  } exp_t;

  exp_t q[$];

  function automatic exp_t mk(logic [3:0] ov, logic [7:0] a, logic [7:0] b,
                              logic [7:0] c, logic [7:0] d, logic fd, logic se,
                              logic [1:0] sel, logic lk);
    exp_t e;
    e.ov = ov; e.a = a; e.b = b; e.c = c; e.d = d;
    e.fd = fd; e.se = se; e.sel = sel; e.lk = lk;
    return e;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.ov = bus.Out_valid; e.a = bus.A; e.b = bus.B; e.c = bus.C; e.d = bus.D;
    e.fd = bus.Frame_done; e.se = bus.Sync_err; e.sel = bus.Sel; e.lk = bus.Locked;
    return e;
  endfunction

  // Monitor: any output pulse consumes one scoreboard entry.
  always @(negedge Clk) begin
    exp_t act, e;
    if (Rst_n && (bus.Out_valid != 4'd0 || bus.Sync_err || bus.Frame_done)) begin
      act = snap();
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got=%h required=<no output>", act);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL scoreboard got=%h required=%h", act, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic beat(input logic [7:0] din, input logic sync, input bit has, input exp_t e);
    @(posedge Clk); #1;
    bus.Din = din; bus.Din_valid = 1'b1; bus.Frame_sync = sync;
    if (has) q.push_back(e);
  endtask

  task automatic idle();
    @(posedge Clk); #1;
    bus.Din_valid = 1'b0; bus.Frame_sync = 1'b0; bus.Din = 8'hxx;
  endtask

  task automatic settle();
    idle();
    @(negedge Clk); #1;
  endtask

  initial begin
    bus.Din = '0; bus.Din_valid = 1'b0; bus.Frame_sync = 1'b0;
    #12;
    chk("reset_state", {bus.A, bus.B, bus.C, bus.D, bus.Out_valid, bus.Sel,
                        bus.Locked, bus.Frame_done, bus.Sync_err}, '0);
    @(negedge Clk); Rst_n = 1'b1;

    // 1: two clean back-to-back frames
    beat(8'h11, 1, 1, mk(4'h1, 8'h11, 8'h00, 8'h00, 8'h00, 0, 0, 2'd1, 1));
    beat(8'h22, 0, 1, mk(4'h2, 8'h11, 8'h22, 8'h00, 8'h00, 0, 0, 2'd2, 1));
    beat(8'h33, 0, 1, mk(4'h4, 8'h11, 8'h22, 8'h33, 8'h00, 0, 0, 2'd3, 1));
    beat(8'h44, 0, 1, mk(4'h8, 8'h11, 8'h22, 8'h33, 8'h44, 1, 0, 2'd0, 1));
    beat(8'h11, 1, 1, mk(4'h1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 2'd1, 1));
    beat(8'h22, 0, 1, mk(4'h2, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 2'd2, 1));
    beat(8'h33, 0, 1, mk(4'h4, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 2'd3, 1));
    beat(8'h44, 0, 1, mk(4'h8, 8'h11, 8'h22, 8'h33, 8'h44, 1, 0, 2'd0, 1));
    settle();
    chk("t1_locked", {bus.Locked, bus.Sel}, {1'b1, 2'd0});

    // 3: sync arriving in slot C restarts the frame
    beat(8'h11, 1, 1, mk(4'h1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 2'd1, 1));
    beat(8'h22, 0, 1, mk(4'h2, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 2'd2, 1));
    beat(8'h77, 1, 1, mk(4'h1, 8'h77, 8'h22, 8'h33, 8'h44, 0, 1, 2'd1, 1));
    beat(8'h88, 0, 1, mk(4'h2, 8'h77, 8'h88, 8'h33, 8'h44, 0, 0, 2'd2, 1));
    beat(8'h99, 0, 1, mk(4'h4, 8'h77, 8'h88, 8'h99, 8'h44, 0, 0, 2'd3, 1));
    beat(8'hAA, 0, 1, mk(4'h8, 8'h77, 8'h88, 8'h99, 8'hAA, 1, 0, 2'd0, 1));
    settle();

    // 4: flywheel through one missed sync, drop lock on the second
    beat(8'h01, 0, 1, mk(4'h1, 8'h01, 8'h88, 8'h99, 8'hAA, 0, 0, 2'd1, 1));
    beat(8'h02, 0, 1, mk(4'h2, 8'h01, 8'h02, 8'h99, 8'hAA, 0, 0, 2'd2, 1));
    beat(8'h03, 0, 1, mk(4'h4, 8'h01, 8'h02, 8'h03, 8'hAA, 0, 0, 2'd3, 1));
    beat(8'h04, 0, 1, mk(4'h8, 8'h01, 8'h02, 8'h03, 8'h04, 1, 0, 2'd0, 1));
    beat(8'h05, 0, 0, '0);
    settle();
    chk("t4_drop", {bus.Locked, bus.Sel, bus.A, bus.D}, {1'b0, 2'd0, 8'h01, 8'h04});

    // 2: after a fresh reset, unsynced beats are ignored in HUNT
    @(negedge Clk); Rst_n = 1'b0;
    @(negedge Clk); Rst_n = 1'b1;
    beat(8'h55, 0, 0, '0);
    beat(8'h66, 0, 0, '0);
    settle();
    chk("t2_hunt", {bus.A, bus.B, bus.C, bus.D, bus.Locked, bus.Sel}, '0);
    beat(8'h12, 1, 1, mk(4'h1, 8'h12, 8'h00, 8'h00, 8'h00, 0, 0, 2'd1, 1));
    settle();
    chk("t2_lock", {bus.Locked, bus.Sel}, {1'b1, 2'd1});

    // 5: beats interleaved with idle cycles
    beat(8'h22, 0, 1, mk(4'h2, 8'h12, 8'h22, 8'h00, 8'h00, 0, 0, 2'd2, 1)); idle();
    beat(8'h33, 0, 1, mk(4'h4, 8'h12, 8'h22, 8'h33, 8'h00, 0, 0, 2'd3, 1)); idle();
    beat(8'h44, 0, 1, mk(4'h8, 8'h12, 8'h22, 8'h33, 8'h44, 1, 0, 2'd0, 1)); idle();
    beat(8'h11, 1, 1, mk(4'h1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 2'd1, 1)); idle();
    beat(8'h22, 0, 1, mk(4'h2, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 2'd2, 1)); idle();
    beat(8'h33, 0, 1, mk(4'h4, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 2'd3, 1)); idle();
    beat(8'h44, 0, 1, mk(4'h8, 8'h11, 8'h22, 8'h33, 8'h44, 1, 0, 2'd0, 1));
    settle();
    chk("t5_regs", {bus.A, bus.B, bus.C, bus.D}, 32'h11223344);

    // 6: asynchronous reset mid-frame, then re-hunt
    beat(8'h11, 1, 1, mk(4'h1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 2'd1, 1));
    beat(8'h22, 0, 1, mk(4'h2, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 2'd2, 1));
    settle();
    chk("t6_presel", bus.Sel, 2'd2);
    #1 Rst_n = 1'b0;
    #1;
    chk("t6_async_rst", {bus.A, bus.B, bus.C, bus.D, bus.Out_valid, bus.Sel,
                         bus.Locked, bus.Frame_done, bus.Sync_err}, '0);
    #1 Rst_n = 1'b1;
    beat(8'h33, 0, 0, '0);
    beat(8'h44, 0, 0, '0);
    settle();
    chk("t6_hunt", {bus.Locked, bus.A, bus.C}, '0);
    beat(8'h5A, 1, 1, mk(4'h1, 8'h5A, 8'h00, 8'h00, 8'h00, 0, 0, 2'd1, 1));
    settle();
    chk("t6_relock", {bus.Locked, bus.A}, {1'b1, 8'h5A});

    repeat (3) @(posedge Clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
